exu_div_seq: RTL and testbench

Multi-cycle sequencer for the RV32M divide group (DIV, DIVU, REM, REMU) inside the execute unit. It sits beside the single-cycle ALU handler on the same `sel`/`inst`/`exu_gpr_if_t.mst` handler contract. It reads both source GPRs on acceptance and runs a 32-iteration restoring divide. It holds the pipeline with `stall` until a single-cycle GPR write-back.

---
 rtl/exu_div_seq_pkg.sv | 42 ++++
 rtl/exu_gpr_if.sv | 13 +
 rtl/exu_div_core.sv | 45 ++++
 rtl/exu_div_seq.sv | 98 +++++++++
 tb/tb_exu_div_seq.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/exu_div_seq_pkg.sv
// exu_div_seq_pkg: shared ISA constants, instruction view and divider FSM state
package exu_div_seq_pkg;
    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [6:0] OPCODE_ALU        = 7'b0110011;
    localparam logic [6:0] ALU_FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] DIV_FUNCT3_DIV  = 3'd4;
    localparam logic [2:0] DIV_FUNCT3_DIVU = 3'd5;
    localparam logic [2:0] DIV_FUNCT3_REM  = 3'd6;
    localparam logic [2:0] DIV_FUNCT3_REMU = 3'd7;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } exu_div_state_t;

    typedef struct packed {
        logic [24:0] rest;
        logic [6:0]  opcode;
    } inst_base_t;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } inst_r_t;

    typedef union packed {
        inst_base_t base;
        inst_r_t    r;
    } rv32i_inst_t;

    function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
        return neg ? -v : v;
    endfunction
endpackage

// File: rtl/exu_gpr_if.sv
// exu_gpr_if_t: EXU handler port onto the GPR file (two comb reads, one write)
interface exu_gpr_if_t;
    import exu_div_seq_pkg::*;
    logic [4:0]      ra1;
    logic [4:0]      ra2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            wen;
    logic [4:0]      wa;
    logic [XLEN-1:0] wd;
    modport mst (output ra1, ra2, wen, wa, wd, input rd1, rd2);
    modport slv (input ra1, ra2, wen, wa, wd, output rd1, rd2);
endinterface

// File: rtl/exu_div_core.sv
// exu_div_core: restoring-divide datapath, one quotient bit per step
module exu_div_core import exu_div_seq_pkg::*; (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] quo_o,
    output logic [XLEN-1:0] rem_o,
    output logic            last_o
);
    logic [XLEN-1:0]  quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN:0]    trial;

    // trial subtract of the shifted partial remainder; restore when it borrows
    always_comb begin
        trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
        rem_d = load_i ? rem_i : step_i ? (trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0]) : rem_q;
        quo_d = load_i ? quo_i : step_i ? {quo_q[XLEN-2:0], ~trial[XLEN]} : quo_q;
        dvs_d = load_i ? dvs_i : dvs_q;
        cnt_d = load_i ? CNT_W'(XLEN - 1) : step_i ? cnt_q - 1'b1 : cnt_q;
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign quo_o  = quo_q;
    assign rem_o  = rem_q;
    assign last_o = (cnt_q == '0);
endmodule

// File: rtl/exu_div_seq.sv
// exu_div_seq: multi-cycle DIV/DIVU/REM/REMU handler with stall and single write-back
module exu_div_seq import exu_div_seq_pkg::*; (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  rv32i_inst_t inst,
    output logic        stall,
    exu_gpr_if_t.mst    gpr_mst
);
    exu_div_state_t  state_q, state_d;
    logic [4:0]      rd_q;
    logic [1:0]      op_q;
    logic            s1_q, s2_q, fast_q;
    logic            is_div, sgn, neg1, neg2, fast, load, step, last;
    logic [XLEN-1:0] a, b, quo, rem, q_fix, r_fix;

    // reset gates acceptance so stall stays low while rst_n is held
    assign is_div = rst_n && sel && inst.base.opcode == OPCODE_ALU
                    && inst.r.funct7 == ALU_FUNCT7_MULDIV && inst.r.funct3[2];
    assign load   = state_q == DIV_IDLE && is_div;
    assign sgn    = ~inst.r.funct3[0];
    assign a      = gpr_mst.rd1;
    assign b      = gpr_mst.rd2;
    assign neg1   = sgn & a[XLEN-1];
    assign neg2   = sgn & b[XLEN-1];
    assign fast   = b == '0 || (sgn && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1);

    assign gpr_mst.ra1 = load ? inst.r.rs1 : 'x;
    assign gpr_mst.ra2 = load ? inst.r.rs2 : 'x;

    // fast-path results are loaded raw and bypass the sign fix
    exu_div_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .step_i (step),
        .quo_i  (fast ? (b == '0 ? '1 : {1'b1, {(XLEN-1){1'b0}}}) : neg_if(neg1, a)),
        .rem_i  (fast && b == '0 ? a : '0),
        .dvs_i  (neg_if(neg2, b)),
        .quo_o  (quo),
        .rem_o  (rem),
        .last_o (last)
    );

    assign q_fix = neg_if(~fast_q & (s1_q ^ s2_q), quo);
    assign r_fix = neg_if(~fast_q & s1_q, rem);

    // FSM next state, stall and write-back port
    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        step        = 1'b0;
        gpr_mst.wen = 1'b0;
        gpr_mst.wa  = 'x;
        gpr_mst.wd  = 'x;
        case (state_q)
            DIV_IDLE: begin
                stall   = load;
                state_d = load ? (fast ? DIV_DONE : DIV_CALC) : DIV_IDLE;
            end
            DIV_CALC: begin
                stall   = 1'b1;
                step    = 1'b1;
                state_d = last ? DIV_DONE : DIV_CALC;
            end
            DIV_DONE: begin
                gpr_mst.wen = rd_q != '0;
                gpr_mst.wa  = rd_q;
                gpr_mst.wd  = op_q[1] ? r_fix : q_fix;
                state_d     = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= DIV_IDLE;
        else        state_q <= state_d;
    end

    // per-op latches captured in the accept cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= '0;
            op_q   <= '0;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            fast_q <= 1'b0;
        end else if (load) begin
            rd_q   <= inst.r.rd;
            op_q   <= inst.r.funct3[1:0];
            s1_q   <= neg1;
            s2_q   <= neg2;
            fast_q <= fast;
        end
    end
endmodule

// File: tb/tb_exu_div_seq.sv
// tb_exu_div_seq: directed vector table plus back-to-back and reset sequences
module tb_exu_div_seq;
    import exu_div_seq_pkg::*;

    typedef struct {
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] wd;
        int          stl;
        int          wens;
    } vec_t;

    localparam logic [6:0] M = ALU_FUNCT7_MULDIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    rv32i_inst_t inst;
    logic        stall;
    logic [31:0] regs [32];
    int          total = 0;
    int          bad = 0;
    vec_t        vecs [27];

    exu_gpr_if_t gpr();
    assign gpr.rd1 = regs[gpr.ra1];
    assign gpr.rd2 = regs[gpr.ra2];

    exu_div_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel     (sel),
        .inst    (inst),
        .stall   (stall),
        .gpr_mst (gpr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic present(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        inst = rv32i_inst_t'({f7, 5'd4, 5'd3, f3, rd, OPCODE_ALU});
    endtask

    task automatic run_op(input vec_t v, output int stl, output int wens,
                          output logic [31:0] wd, output logic [4:0] wa, output int wen_at);
        logic done;
        @(negedge clk);
        regs[3] = v.a;
        regs[4] = v.b;
        present(v.f7, v.f3, v.rd);
        sel = 1'b1;
        stl = 0; wens = 0; wd = '0; wa = '0; wen_at = -1; done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            #1;
            if (gpr.wen) begin
                wens++;
                wd = gpr.wd;
                wa = gpr.wa;
                wen_at = i;
            end
            if (stall) stl++;
            else begin
                sel = 1'b0;
                done = 1'b1;
            end
            if (!done) @(negedge clk);
        end
        sel = 1'b0;
        check("op_finished", 32'(done), 32'd1);
        @(negedge clk);
        #1;
        if (gpr.wen) wens++;
    endtask

    initial begin
        int          stl, wens, wen_at, n;
        logic [31:0] wd;
        logic [4:0]  wa;
        int          times [2];
        logic [31:0] wds [2];
        logic [4:0]  was [2];

        vecs[0]  = '{M, DIV_FUNCT3_DIVU, 5'd5,  32'd7,        32'd2,        32'd3,        33, 1};
        vecs[1]  = '{M, DIV_FUNCT3_REMU, 5'd5,  32'd7,        32'd2,        32'd1,        33, 1};
        vecs[2]  = '{M, DIV_FUNCT3_DIV,  5'd5,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 1};
        vecs[3]  = '{M, DIV_FUNCT3_REM,  5'd5,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 1};
        vecs[4]  = '{M, DIV_FUNCT3_DIV,  5'd5,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        33, 1};
        vecs[5]  = '{M, DIV_FUNCT3_REM,  5'd5,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 33, 1};
        vecs[6]  = '{M, DIV_FUNCT3_DIV,  5'd5,  32'd5,        32'd0,        32'hFFFFFFFF, 1,  1};
        vecs[7]  = '{M, DIV_FUNCT3_REMU, 5'd5,  32'd5,        32'd0,        32'd5,        1,  1};
        vecs[8]  = '{M, DIV_FUNCT3_DIV,  5'd5,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1};
        vecs[9]  = '{M, DIV_FUNCT3_REM,  5'd5,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  1};
        vecs[10] = '{M, DIV_FUNCT3_DIVU, 5'd5,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33, 1};
        vecs[11] = '{M, DIV_FUNCT3_DIVU, 5'd9,  32'h80000000, 32'hFFFFFFFF, 32'd0,        33, 1};
        vecs[12] = '{M, DIV_FUNCT3_REMU, 5'd9,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 1};
        vecs[13] = '{M, DIV_FUNCT3_DIV,  5'd10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1,  1};
        vecs[14] = '{M, DIV_FUNCT3_REM,  5'd10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1,  1};
        vecs[15] = '{M, DIV_FUNCT3_DIV,  5'd11, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33, 1};
        vecs[16] = '{M, DIV_FUNCT3_REM,  5'd11, 32'd100,      32'hFFFFFFF9, 32'd2,        33, 1};
        vecs[17] = '{M, DIV_FUNCT3_DIVU, 5'd12, 32'h12345678, 32'h1234,     32'h00010004, 33, 1};
        vecs[18] = '{M, DIV_FUNCT3_REMU, 5'd12, 32'h12345678, 32'h1234,     32'h00000DA8, 33, 1};
        vecs[19] = '{M, DIV_FUNCT3_DIV,  5'd13, 32'h80000000, 32'd2,        32'hC0000000, 33, 1};
        vecs[20] = '{M, DIV_FUNCT3_DIV,  5'd13, 32'h80000000, 32'd3,        32'hD5555556, 33, 1};
        vecs[21] = '{M, DIV_FUNCT3_REM,  5'd13, 32'h80000000, 32'd3,        32'hFFFFFFFE, 33, 1};
        vecs[22] = '{M, DIV_FUNCT3_DIV,  5'd0,  32'd7,        32'd2,        32'd0,        33, 0};
        vecs[23] = '{7'd0, 3'd0,         5'd5,  32'd7,        32'd2,        32'd0,        0,  0};
        vecs[24] = '{M, 3'd0,            5'd5,  32'd7,        32'd2,        32'd0,        0,  0};
        vecs[25] = '{7'd0, 3'd4,         5'd5,  32'd7,        32'd2,        32'd0,        0,  0};
        vecs[26] = '{M, 3'd3,            5'd5,  32'd7,        32'd2,        32'd0,        0,  0};

        for (int i = 0; i < 32; i++) regs[i] = '0;
        inst = '0;
        #12;
        sel = 1'b1;
        present(M, DIV_FUNCT3_DIV, 5'd5);
        #1;
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_wen", 32'(gpr.wen), 32'd0);
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 27; k++) begin
            run_op(vecs[k], stl, wens, wd, wa, wen_at);
            check($sformatf("v%0d_stall", k), 32'(stl), 32'(vecs[k].stl));
            check($sformatf("v%0d_wens", k), 32'(wens), 32'(vecs[k].wens));
            if (vecs[k].wens > 0) begin
                check($sformatf("v%0d_wd", k), wd, vecs[k].wd);
                check($sformatf("v%0d_wa", k), 32'(wa), 32'(vecs[k].rd));
                check($sformatf("v%0d_lat", k), 32'(wen_at), 32'(vecs[k].stl));
            end
        end

        // back-to-back: second op presented during DONE of the first
        @(negedge clk);
        regs[3] = 32'd7;
        regs[4] = 32'd2;
        present(M, DIV_FUNCT3_DIVU, 5'd5);
        sel = 1'b1;
        n = 0;
        for (int i = 0; i < 100 && n < 2; i++) begin
            #1;
            if (gpr.wen) begin
                times[n] = i;
                wds[n] = gpr.wd;
                was[n] = gpr.wa;
                n++;
                if (n == 1) present(M, DIV_FUNCT3_REMU, 5'd6);
                else sel = 1'b0;
            end
            if (n < 2) @(negedge clk);
        end
        sel = 1'b0;
        check("b2b_count", 32'(n), 32'd2);
        if (n == 2) begin
            check("b2b_gap", 32'(times[1] - times[0]), 32'd34);
            check("b2b_wd0", wds[0], 32'd3);
            check("b2b_wa0", 32'(was[0]), 32'd5);
            check("b2b_wd1", wds[1], 32'd1);
            check("b2b_wa1", 32'(was[1]), 32'd6);
        end
        repeat (2) @(negedge clk);

        // async reset in CALC cycle 10 drops stall at once and kills the write-back
        regs[3] = 32'd7;
        regs[4] = 32'd2;
        present(M, DIV_FUNCT3_DIVU, 5'd5);
        sel = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("calc10_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_stall", 32'(stall), 32'd0);
        check("rst_async_wen", 32'(gpr.wen), 32'd0);
        sel = 1'b0;
        wens = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            #1;
            if (gpr.wen) wens++;
        end
        check("rst_no_wb", 32'(wens), 32'd0);

        run_op('{M, DIV_FUNCT3_DIVU, 5'd7, 32'd100, 32'd7, 32'd14, 33, 1}, stl, wens, wd, wa, wen_at);
        check("post_rst_stall", 32'(stl), 32'd33);
        check("post_rst_wens", 32'(wens), 32'd1);
        check("post_rst_wd", wd, 32'd14);
        check("post_rst_wa", 32'(wa), 32'd7);
        check("post_rst_lat", 32'(wen_at), 32'd33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
